// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, ALU and multiply/divide op encodings.
// Also holds the multiply/divide iteration count.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU
  } muldiv_op_t;

  localparam int MULDIV_ITER = 32;
  localparam int MULDIV_CW   = $clog2(MULDIV_ITER);

endpackage

// File: rtl/muldiv_if.sv
// Bundle of the multiply/divide unit signals.
// Side views for the unit itself and for a driver.
interface muldiv_if
  import cpu_types_pkg::*;
(
  input logic CLK
);

  logic       RST;
  logic       start;
  muldiv_op_t op;
  word_t      pa;
  word_t      pb;
  logic       hi_wen;
  logic       lo_wen;
  word_t      wdat;
  logic       busy;
  logic       done;
  word_t      hi;
  word_t      lo;

  modport muldiv (
    input  CLK, RST, start, op, pa, pb,
    input  hi_wen, lo_wen, wdat,
    output busy, done, hi, lo
  );

  modport tb (
    input  CLK, busy, done, hi, lo,
    output RST, start, op, pa, pb,
    output hi_wen, lo_wen, wdat
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixed at end.
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      pa,
  input  word_t      pb,
  input  logic       hi_wen,
  input  logic       lo_wen,
  input  word_t      wdat,
  output logic       busy,
  output logic       done,
  output word_t      hi,
  output word_t      lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam logic [MULDIV_CW-1:0] CNT_LAST =
    MULDIV_CW'(MULDIV_ITER - 1);

  state_t state, state_d;

  logic [MULDIV_CW-1:0] cnt;
  logic        last;
  logic [63:0] acc;
  word_t       opnd;
  word_t       pa_q;
  logic        neg_q;
  logic        rneg_q;
  logic        div0_q;

  logic        accept;
  logic        is_mul_op;
  logic        signed_op;
  word_t       mag_a;
  word_t       mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] res;

  function automatic logic [63:0] fix_sign(
    input logic        is_mul,
    input logic [63:0] r,
    input logic        neg,
    input logic        rneg,
    input logic        div0,
    input word_t       a
  );
    logic [63:0] f;
    word_t       q;
    word_t       rm;
    if (is_mul) begin
      f = neg ? -r : r;
    end else if (div0) begin
      f = {a, 32'hFFFF_FFFF};
    end else begin
      q  = neg  ? -r[31:0]  : r[31:0];
      rm = rneg ? -r[63:32] : r[63:32];
      f  = {rm, q};
    end
    return f;
  endfunction

  // operand decode and one iteration of each algorithm
  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    mag_a     = (signed_op && pa[31]) ? -pa : pa;
    mag_b     = (signed_op && pb[31]) ? -pb : pb;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opnd : 32'd0};
    mul_next  = {mul_sum, acc[31:1]};
    div_diff  = {1'b0, acc[63:31]} - {2'b00, opnd};
    div_next  = div_diff[33] ? {acc[62:0], 1'b0}
                             : {div_diff[31:0], acc[30:0], 1'b1};
    res       = fix_sign(state == MUL, acc, neg_q, rneg_q, div0_q, pa_q);
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // next state and status outputs
  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_d = is_mul_op ? MUL : DIV;
        else       state_d = IDLE;
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath: operand latch, iteration, result and mthi/mtlo writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      last   <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      pa_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        last   <= 1'b0;
        acc    <= {32'd0, is_mul_op ? mag_b : mag_a};
        opnd   <= is_mul_op ? mag_a : mag_b;
        pa_q   <= pa;
        neg_q  <= signed_op && (pa[31] ^ pb[31]);
        rneg_q <= (op == MD_DIV) && pa[31];
        div0_q <= (pb == '0);
      end else if (busy) begin
        if (last) begin
          last     <= 1'b0;
          {hi, lo} <= res;
        end else begin
          acc <= (state == MUL) ? mul_next : div_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) last <= 1'b1;
        end
      end
      if (!busy) begin
        if (hi_wen) hi <= wdat;
        if (lo_wen) lo <= wdat;
      end
    end
  end

endmodule
